wb_regfile: RTL

- Write-back sink and architectural register file for the Y86-64 pipeline.
- Consumes the W-stage register outputs (stat, icode, valE, valM, dstE, dstM) and commits results to 15 64-bit registers.
- Serves the two decode-stage read ports.
- Tracks the processor status (run/halted on a non-AOK stat) and counts retired instructions.

---
 rtl/wb_regfile_pkg.sv | 34 +++
 rtl/wb_regfile_status_fsm.sv | 80 ++++++++
 rtl/wb_regfile.sv | 109 ++++++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg
//   Shared constants for the Y86-64 write-back stage: data widths, the
//   "no register" ID, status codes, instruction codes and the encoding of
//   the write-back status FSM states.
//   No ports; import with "import wb_regfile_pkg::*;".
package wb_regfile_pkg;

    localparam int NIBBLE = 4;
    localparam int D_WORD = 64;

    localparam logic [NIBBLE-1:0] RNONE = 4'hF;

    localparam logic [NIBBLE-1:0] S_AOK = 4'h1;
    localparam logic [NIBBLE-1:0] S_HLT = 4'h2;
    localparam logic [NIBBLE-1:0] S_ADR = 4'h3;
    localparam logic [NIBBLE-1:0] S_INS = 4'h4;

    localparam logic [NIBBLE-1:0] I_HALT   = 4'h0;
    localparam logic [NIBBLE-1:0] I_NOP    = 4'h1;
    localparam logic [NIBBLE-1:0] I_RRMOVQ = 4'h2;
    localparam logic [NIBBLE-1:0] I_IRMOVQ = 4'h3;
    localparam logic [NIBBLE-1:0] I_RMMOVQ = 4'h4;
    localparam logic [NIBBLE-1:0] I_MRMOVQ = 4'h5;
    localparam logic [NIBBLE-1:0] I_OPQ    = 4'h6;
    localparam logic [NIBBLE-1:0] I_JXX    = 4'h7;
    localparam logic [NIBBLE-1:0] I_CALL   = 4'h8;
    localparam logic [NIBBLE-1:0] I_RET    = 4'h9;
    localparam logic [NIBBLE-1:0] I_PUSHQ  = 4'hA;
    localparam logic [NIBBLE-1:0] I_POPQ   = 4'hB;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/wb_regfile_status_fsm.sv
// wb_status_fsm
//   RUN/HALTED status machine for the write-back stage. Decides whether the
//   instruction currently in W may commit, tracks the architectural status
//   and keeps a saturating count of retired (non-bubble) instructions.
//
//   Ports:
//     clk_i       clock
//     rstn_i      asynchronous active-low reset
//     w_stat_i    status of the instruction in W
//     w_icode_i   icode of the instruction in W
//     restart_i   single-cycle pulse that leaves HALTED
//     commit_en_o high when the W instruction may write the register file
//     cpu_stat_o  architectural status code
//     halted_o    high while HALTED
//     retired_o   retired-instruction count (saturating)
module wb_status_fsm
    import wb_regfile_pkg::*;
#(
    parameter int               CNT_W     = 32,
    parameter logic [NIBBLE-1:0] P_S_AOK  = S_AOK,
    parameter logic [NIBBLE-1:0] P_I_NOP  = I_NOP
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NIBBLE-1:0] w_stat_i,
    input  logic [NIBBLE-1:0] w_icode_i,
    input  logic              restart_i,
    output logic              commit_en_o,
    output logic [NIBBLE-1:0] cpu_stat_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  retired_o
);

    logic [0:0] state;

    // A faulting instruction is the one that moves us to HALTED, so it is
    // excluded from commit by the same AOK test that qualifies everything else.
    assign commit_en_o = (state == ST_RUN) && (w_stat_i == P_S_AOK);
    assign halted_o    = (state == ST_HALTED);

    // Status machine: the faulting status is latched so software can see why
    // the pipeline stopped; restart returns to normal operation.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= ST_RUN;
            cpu_stat_o <= P_S_AOK;
        end else begin
            case (state)
                ST_RUN: begin
                    if (w_stat_i != P_S_AOK) begin
                        state      <= ST_HALTED;
                        cpu_stat_o <= w_stat_i;
                    end
                end
                ST_HALTED: begin
                    if (restart_i) begin
                        state      <= ST_RUN;
                        cpu_stat_o <= P_S_AOK;
                    end
                end
                default: begin
                    state      <= ST_RUN;
                    cpu_stat_o <= P_S_AOK;
                end
            endcase
        end
    end

    // Retire counter: bubbles still pass through commit but do not count.
    // It sticks at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            retired_o <= '0;
        end else if (commit_en_o && (w_icode_i != P_I_NOP)
                     && (retired_o != {CNT_W{1'b1}})) begin
            retired_o <= retired_o + 1'b1;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile
//   Write-back sink and architectural register file for the Y86-64 pipeline.
//   Commits valE/valM from the W stage into 15 64-bit registers, serves the
//   two combinational decode read ports, and wraps wb_status_fsm for the
//   RUN/HALTED status and retire count.
//
//   Optional feature macro: WB_BYPASS_EN
//     defined   - a read port whose source matches a committing W destination
//                 returns the incoming value in the same cycle (valM wins).
//     undefined - read ports return stored values only.
//
//   Ports:
//     clk_i, rstn_i            clock, asynchronous active-low reset
//     W_stat_i, W_icode_i      status and icode of the instruction in W
//     W_valE_i, W_valM_i       results to commit
//     W_dstE_i, W_dstM_i       destinations (0xF = none)
//     d_srcA_i, d_srcB_i       decode read-port register IDs
//     d_rvalA_o, d_rvalB_o     decode read-port data
//     restart_i                pulse to leave HALTED
//     cpu_stat_o, halted_o     architectural status
//     retired_o                retired-instruction count
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int               NREG  = 15,
    parameter int               CNT_W = 32,
    parameter logic [NIBBLE-1:0] S_AOK = wb_regfile_pkg::S_AOK,
    parameter logic [NIBBLE-1:0] I_NOP = wb_regfile_pkg::I_NOP
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NIBBLE-1:0] W_stat_i,
    input  logic [NIBBLE-1:0] W_icode_i,
    input  logic [D_WORD-1:0] W_valE_i,
    input  logic [D_WORD-1:0] W_valM_i,
    input  logic [NIBBLE-1:0] W_dstE_i,
    input  logic [NIBBLE-1:0] W_dstM_i,
    input  logic [NIBBLE-1:0] d_srcA_i,
    input  logic [NIBBLE-1:0] d_srcB_i,
    output logic [D_WORD-1:0] d_rvalA_o,
    output logic [D_WORD-1:0] d_rvalB_o,
    input  logic              restart_i,
    output logic [NIBBLE-1:0] cpu_stat_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  retired_o
);

    logic [D_WORD-1:0] regs [NREG];
    logic              commit_en;

    wb_status_fsm #(
        .CNT_W   (CNT_W),
        .P_S_AOK (S_AOK),
        .P_I_NOP (I_NOP)
    ) u_status (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .w_stat_i    (W_stat_i),
        .w_icode_i   (W_icode_i),
        .restart_i   (restart_i),
        .commit_en_o (commit_en),
        .cpu_stat_o  (cpu_stat_o),
        .halted_o    (halted_o),
        .retired_o   (retired_o)
    );

    // Register array. The M port is written after the E port so that when
    // both target the same register the memory result wins.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_en) begin
            if (W_dstE_i != RNONE) begin
                regs[W_dstE_i] <= W_valE_i;
            end
            if (W_dstM_i != RNONE) begin
                regs[W_dstM_i] <= W_valM_i;
            end
        end
    end

    // Shared read-port lookup. With bypass enabled, a committing destination
    // that matches the source overrides storage; valM is checked last so it
    // takes priority over valE.
    function automatic logic [D_WORD-1:0] read_port(input logic [NIBBLE-1:0] src);
        logic [D_WORD-1:0] val;
        val = '0;
        if (src != RNONE) begin
            val = regs[src];
`ifdef WB_BYPASS_EN
            if (commit_en && (W_dstE_i == src)) begin
                val = W_valE_i;
            end
            if (commit_en && (W_dstM_i == src)) begin
                val = W_valM_i;
            end
`endif
        end
        return val;
    endfunction

    always_comb begin
        d_rvalA_o = read_port(d_srcA_i);
        d_rvalB_o = read_port(d_srcB_i);
    end

endmodule
